// File: rtl/topo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : topo_pkg
//  Description : Shared constants for the whack-a-mole sequencer and the
//                cell array: FSM state codes, LFSR taps, default timing and
//                the RGB colour codes used by the cells.
//  Revision    : 1.0 - initial release
// ============================================================================
package topo_pkg;

    // Sequencer state codes. Plain constants keep them usable from older tools.
    typedef logic [2:0] topo_state_t;
    localparam topo_state_t ST_IDLE   = 3'd0;
    localparam topo_state_t ST_ESPERA = 3'd1;
    localparam topo_state_t ST_TOPO   = 3'd2;
    localparam topo_state_t ST_GOLPE  = 3'd3;
    localparam topo_state_t ST_FIN    = 3'd4;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0].
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Default build configuration.
    localparam int         DEF_NUM_CELDAS    = 9;
    localparam int         DEF_TIEMPO_TOPO   = 50_000_000;
    localparam int         DEF_TIEMPO_ESPERA = 25_000_000;
    localparam int         DEF_MAX_FALLOS    = 5;
    localparam int         DEF_SCORE_W       = 8;
    localparam logic [7:0] DEF_LFSR_SEED     = 8'hA5;

    // Colour codes shown by a cell, shared with the cell array.
    localparam logic [2:0] RGB_APAGADO = 3'b000;
    localparam logic [2:0] RGB_TOPO    = 3'b010;
    localparam logic [2:0] RGB_GOLPE   = 3'b100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/topo_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : topo_control_if
//  Description : Bundle between the game sequencer (master) and the cell
//                array / game front-end (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface topo_control_if #(
    parameter int NUM_CELDAS = 9,
    parameter int SCORE_W    = 8
);
    logic                  start;
    logic [NUM_CELDAS-1:0] hit;
    logic [NUM_CELDAS-1:0] poner_topo;
    logic [SCORE_W-1:0]    score;
    logic [3:0]            fallos;
    logic                  jugando;
    logic                  game_over;

    modport master (
        input  start, hit,
        output poner_topo, score, fallos, jugando, game_over
    );

    modport slave (
        output start, hit,
        input  poner_topo, score, fallos, jugando, game_over
    );
endinterface
`default_nettype wire

// File: rtl/topo_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : topo_lfsr
//  Description : 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4) with a
//                reset seed. A nonzero seed never reaches the all-zero state.
//  Revision    : 1.0 - initial release
// ============================================================================
module topo_lfsr
    import topo_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [7:0] lfsr_o
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb;

    assign fb = ^(lfsr_q & LFSR_TAPS);

    // Shift in the tap parity when enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[6:0], fb};
        end
    end

    // State register, seeded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;
endmodule
`default_nettype wire

// File: rtl/topo_control.sv
`default_nettype none
// ============================================================================
//  Module      : topo_control
//  Description : Whack-a-mole game sequencer. Raises a mole on a
//                pseudo-random cell (never the same cell twice in a row),
//                counts hits and misses, and ends the game after MAX_FALLOS
//                misses.
//  Options     : TOPO_SPEEDUP_EN - each counted hit shortens the mole
//                lifetime by 1/8, floored at TIEMPO_TOPO/4.
//  Revision    : 1.0 - initial release
// ============================================================================
module topo_control
    import topo_pkg::*;
#(
    parameter int         NUM_CELDAS    = DEF_NUM_CELDAS,
    parameter int         TIEMPO_TOPO   = DEF_TIEMPO_TOPO,
    parameter int         TIEMPO_ESPERA = DEF_TIEMPO_ESPERA,
    parameter int         MAX_FALLOS    = DEF_MAX_FALLOS,
    parameter int         SCORE_W       = DEF_SCORE_W,
    parameter logic [7:0] LFSR_SEED     = DEF_LFSR_SEED
) (
    input  logic          clk,
    input  logic          rst_n,
    topo_control_if.master bus
);
    localparam int TW = $clog2(max_int(TIEMPO_TOPO, TIEMPO_ESPERA) + 1);
    localparam int IW = (NUM_CELDAS > 1) ? $clog2(NUM_CELDAS) : 1;

    localparam logic [TW-1:0]         ESPERA_ULT = TW'(TIEMPO_ESPERA - 1);
    localparam logic [3:0]            FALLOS_FIN = 4'(MAX_FALLOS);
    localparam logic [NUM_CELDAS-1:0] CELDA_0    = NUM_CELDAS'(1);

    topo_state_t           state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         cur_idx_q, cur_idx_d;
    logic [IW-1:0]         last_idx_q, last_idx_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [3:0]            fallos_q, fallos_d;
    logic [NUM_CELDAS-1:0] poner_q, poner_d;

    logic [7:0]            lfsr;
    logic [7:0]            cand_full;
    logic [IW-1:0]         cand;
    logic [IW:0]           cand_inc;
    logic [IW-1:0]         idx;
    logic                  hit_sel;
    logic                  timeout;
    logic [3:0]            fallos_inc;

    // Free-running random source; it keeps advancing in every state so the
    // pick depends on how long the player took.
    topo_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    // Cell pick: skip forward one cell when the draw repeats the last mole.
    always_comb begin
        cand_full = lfsr % 8'(NUM_CELDAS);
        cand      = cand_full[IW-1:0];
        cand_inc  = {1'b0, cand} + 1'b1;
        idx       = cand;
        if (cand == last_idx_q) begin
            idx = (cand_inc == (IW+1)'(NUM_CELDAS)) ? '0 : cand_inc[IW-1:0];
        end
    end

    assign hit_sel    = bus.hit[cur_idx_q];
    assign fallos_inc = fallos_q + 4'd1;

`ifdef TOPO_SPEEDUP_EN
    localparam logic [TW-1:0] VIDA_MIN = TW'(TIEMPO_TOPO / 4);

    logic [TW-1:0] vida_q, vida_d;
    logic [TW-1:0] vida_dec;

    // Lifetime after one more hit, never below the floor.
    always_comb begin
        vida_dec = vida_q - (vida_q >> 3);
        if (vida_dec < VIDA_MIN) begin
            vida_dec = VIDA_MIN;
        end
    end

    assign timeout = (timer_q == (vida_q - 1'b1));

    // Lifetime register: restored on a new game, shrunk on each counted hit.
    always_comb begin
        vida_d = vida_q;
        if ((state_q == ST_IDLE || state_q == ST_FIN) && bus.start) begin
            vida_d = TW'(TIEMPO_TOPO);
        end else if (state_q == ST_TOPO && hit_sel) begin
            vida_d = vida_dec;
        end
    end

    // Lifetime state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vida_q <= TW'(TIEMPO_TOPO);
        end else begin
            vida_q <= vida_d;
        end
    end
`else
    localparam logic [TW-1:0] TOPO_ULT = TW'(TIEMPO_TOPO - 1);

    assign timeout = (timer_q == TOPO_ULT);
`endif

    // Game FSM next state. The mole output is registered and computed for the
    // state being entered, so it is valid from the first TOPO cycle and is
    // already low during GOLPE.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cur_idx_d  = cur_idx_q;
        last_idx_d = last_idx_q;
        score_d    = score_q;
        fallos_d   = fallos_q;
        poner_d    = '0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (bus.start) begin
                    state_d  = ST_ESPERA;
                    score_d  = '0;
                    fallos_d = '0;
                    timer_d  = '0;
                end
            end
            ST_ESPERA: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == ESPERA_ULT) begin
                    state_d    = ST_TOPO;
                    cur_idx_d  = idx;
                    last_idx_d = idx;
                    timer_d    = '0;
                    poner_d    = CELDA_0 << idx;
                end
            end
            ST_TOPO: begin
                timer_d = timer_q + 1'b1;
                poner_d = poner_q;
                if (hit_sel) begin
                    // A hit wins over a simultaneous timeout.
                    score_d = (score_q == '1) ? score_q : score_q + 1'b1;
                    state_d = ST_GOLPE;
                    timer_d = '0;
                    poner_d = '0;
                end else if (timeout) begin
                    fallos_d = fallos_inc;
                    state_d  = (fallos_inc == FALLOS_FIN) ? ST_FIN : ST_ESPERA;
                    timer_d  = '0;
                    poner_d  = '0;
                end
            end
            ST_GOLPE: begin
                // One idle cycle with the mole lowered so the cell's HIT
                // drops before the next mole; a held hit is not recounted.
                state_d = ST_ESPERA;
                timer_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Game state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            cur_idx_q  <= '0;
            last_idx_q <= '0;
            score_q    <= '0;
            fallos_q   <= '0;
            poner_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cur_idx_q  <= cur_idx_d;
            last_idx_q <= last_idx_d;
            score_q    <= score_d;
            fallos_q   <= fallos_d;
            poner_q    <= poner_d;
        end
    end

    assign bus.poner_topo = poner_q;
    assign bus.score      = score_q;
    assign bus.fallos     = fallos_q;
    assign bus.jugando    = (state_q == ST_ESPERA) || (state_q == ST_TOPO) ||
                            (state_q == ST_GOLPE);
    assign bus.game_over  = (state_q == ST_FIN);
endmodule
`default_nettype wire

// File: doc/topo_control.md
Name: topo_control

Overview:
- Game sequencer directly upstream of the per-cell mole array; drives each cell's PONER_TOPO input and consumes each cell's HIT output.
- Picks a pseudo-random cell and raises a mole there for a bounded time.
- Counts hits (score) and timeouts (misses) and ends the game after a configured number of misses.

Parameters:
- NUM_CELDAS, 9, number of mole cells (2..16)
- TIEMPO_TOPO, 50_000_000, clock cycles a mole stays up
- TIEMPO_ESPERA, 25_000_000, clock cycles between moles
- MAX_FALLOS, 5, misses that end the game (1..15)
- SCORE_W, 8, score counter width
- LFSR_SEED, 8'hA5, LFSR reset value (nonzero)

Ports:
- Clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; high in IDLE/FIN starts a new game
- hit  in  NUM_CELDAS  per-cell HIT from the cell array
- poner_topo  out  NUM_CELDAS  one-hot (or zero) mole placement to the cells
- score  out  SCORE_W  hits this game
- fallos  out  4  misses this game
- jugando  out  1  high while a game is in progress
- game_over  out  1  high in FIN

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; poner_topo=0, score=0, fallos=0, jugando=0, game_over=0.
  - timer=0, lfsr=LFSR_SEED, last_idx=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle regardless of state (never 0).
- Cell pick, combinational:
  - cand = lfsr % NUM_CELDAS.
  - If cand==last_idx, idx = (cand+1) % NUM_CELDAS; else idx = cand.
  - The same cell is never chosen twice in a row.
- FSM states: IDLE, ESPERA, TOPO, GOLPE, FIN.
- IDLE:
  - outputs as in reset.
  - start=1 -> ESPERA next cycle; score and fallos cleared, timer=0, jugando=1.
- ESPERA:
  - poner_topo=0; timer increments.
  - At timer==TIEMPO_ESPERA-1 -> TOPO; latch idx into cur_idx and last_idx; timer=0.
- TOPO:
  - poner_topo = 1<<cur_idx (registered, asserted from the first TOPO cycle); timer increments.
  - Priority 1: hit[cur_idx]=1 -> score+1 (saturates at all-ones), -> GOLPE.
  - Priority 2: else if timer==TIEMPO_TOPO-1 -> fallos+1 -> FIN if the new fallos==MAX_FALLOS, else ESPERA; timer=0.
  - Hit on the last cycle counts as a hit, not a miss.
  - hit bits of other cells are ignored.
- GOLPE:
  - Exactly 1 cycle; poner_topo=0 (clears the cell's mole so its HIT drops).
  - -> ESPERA, timer=0.
  - Guarantees one hit counted per mole even if hit is held high.
- FIN: jugando=0, game_over=1, poner_topo=0; score and fallos hold; start=1 -> IDLE-style clear, then ESPERA.
- start is ignored in ESPERA/TOPO/GOLPE.
- Async reset mid-game returns to IDLE immediately; poner_topo drops without waiting for a clock edge.
- Timer width: $clog2(max(TIEMPO_TOPO,TIEMPO_ESPERA)+1).

Optional Feature:
- TOPO_SPEEDUP_EN defined:
  - Mole lifetime is a register vida, reset/new-game value TIEMPO_TOPO.
  - Each counted hit sets vida = vida - (vida>>3), floored at TIEMPO_TOPO/4.
  - The TOPO timeout compares against vida-1.
- Not defined: lifetime is the constant TIEMPO_TOPO; no vida register.

Decomposition:
- Shared package topo_pkg:
  - state enum (IDLE, ESPERA, TOPO, GOLPE, FIN)
  - LFSR taps constant
  - default NUM_CELDAS/timing constants
  - RGB colour codes shared with the cell array
- Natural sub-module: topo_lfsr (8-bit LFSR with seed parameter, enable tied high). Pick logic and FSM remain in topo_control.

Test Plan (NUM_CELDAS=4, TIEMPO_TOPO=8, TIEMPO_ESPERA=4, MAX_FALLOS=3, SCORE_W=8):
- Reset/start:
  - reset=0 mid-TOPO -> poner_topo=0 asynchronously, all outputs 0.
  - Release, start=1 one cycle -> jugando=1; poner_topo one-hot exactly 5 cycles after the start edge (1 to ESPERA + 4 wait).
- Hit:
  - Assert hit[cur_idx] on the 3rd TOPO cycle, held 5 cycles -> score=1, next cycle poner_topo=0, next mole after 1+4 cycles.
  - Score counts only once.
- Timeout:
  - No hits -> poner_topo high for exactly 8 cycles, fallos increments.
  - After the 3rd miss: game_over=1, jugando=0, score holds.
- Boundary:
  - hit[cur_idx] on the final (8th) TOPO cycle -> score+1, fallos unchanged.
  - hit on a non-selected cell -> ignored.
- Non-repeat: over 200 consecutive moles, cur_idx never equals the previous and all 4 cells appear.
- TOPO_SPEEDUP_EN with TIEMPO_TOPO=64: successive hits give lifetimes 64, 56, 49, 43, …, floored at 16.
